// File: rtl/vc_dest_arbiter_if.sv
// Bus bundle between vc_dest_arbiter and its FIFOs: the VC source read side and
// the shared destination write side.
interface vc_dest_arbiter_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic                  vc0_error;
  logic                  vc1_error;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  d0_full;
  logic                  d0_almost_full;
  logic                  d1_full;
  logic                  d1_almost_full;
  logic                  d0_error;
  logic                  d1_error;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] d_data;

  modport master (
    input  vc0_empty, vc1_empty, vc0_error, vc1_error, vc0_data, vc1_data,
    input  d0_full, d0_almost_full, d1_full, d1_almost_full, d0_error, d1_error,
    output vc0_pop, vc1_pop, d0_push, d1_push, d_data
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_error, vc1_error, vc0_data, vc1_data,
    output d0_full, d0_almost_full, d1_full, d1_almost_full, d0_error, d1_error,
    input  vc0_pop, vc1_pop, d0_push, d1_push, d_data
  );
endinterface

// File: rtl/vc_dest_arbiter.sv
// Moves words from VC0/VC1 source FIFOs into D0/D1 destination FIFOs: VC0-priority
// arbitration with a starvation limit, routing on one destination bit of each word.
module vc_dest_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int MAX_HOLD   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  vc_dest_arbiter_if.master     bus,
  output logic                  idle,
  output logic                  error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam int              HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [1:0]            state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  sel_q, sel_d;

  logic                  any_err;
  logic                  room;
  logic                  grant0;
  logic                  grant1;
  logic                  push_ok;
  logic [DATA_WIDTH-1:0] word;

  // Two free slots per destination cover the word in flight plus the one popped now.
  always_comb begin
    any_err = bus.vc0_error | bus.vc1_error | bus.d0_error | bus.d1_error;
    room    = ~bus.d0_full & ~bus.d0_almost_full & ~bus.d1_full & ~bus.d1_almost_full;
    grant0  = 1'b0;
    grant1  = 1'b0;
    if ((state_q == ST_ACTIVE) && room && !any_err && !reset) begin
      if (!bus.vc0_empty && !((hold_cnt_q == HOLD_MAX) && !bus.vc1_empty)) begin
        grant0 = 1'b1;
      end else if (!bus.vc1_empty) begin
        grant1 = 1'b1;
      end
    end
  end

  // The popped word arrives one cycle later from the FIFO's read register.
  always_comb begin
    word        = sel_q ? bus.vc1_data : bus.vc0_data;
    push_ok     = inflight_q & (state_q != ST_ERROR) & ~reset;
    bus.vc0_pop = grant0;
    bus.vc1_pop = grant1;
    bus.d_data  = push_ok ? word : '0;
    bus.d0_push = push_ok & ~word[DEST_BIT];
    bus.d1_push = push_ok & word[DEST_BIT];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!enable) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_IDLE;
      default:   state_d = ST_ERROR;
    endcase
    if (any_err) begin
      state_d = ST_ERROR;
    end

    inflight_d = grant0 | grant1;
    sel_d      = (grant0 | grant1) ? grant1 : sel_q;

    hold_cnt_d = hold_cnt_q;
    if (bus.vc1_empty || grant1) begin
      hold_cnt_d = '0;
    end else if (grant0 && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      inflight_q <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      inflight_q <= inflight_d;
      sel_q      <= sel_d;
    end
  end

  assign error = (state_q == ST_ERROR);
  assign idle  = (state_q == ST_IDLE) & ~inflight_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Randomized scoreboard bench for vc_dest_arbiter: queue-based FIFO environment,
// rule-level reference model, and a negedge monitor that pops expectations.
module tb_vc_dest_arbiter;
  localparam int DW    = 6;
  localparam int DB    = 4;
  localparam int MH    = 3;
  localparam int DEPTH = 8;

  localparam int M_OFF  = 0;
  localparam int M_RUN  = 1;
  localparam int M_FIN  = 2;
  localparam int M_HALT = 3;

  typedef struct {
    bit pop0;
    bit pop1;
    bit idle;
    bit err;
    bit dzero;
    bit skip_state;
  } cyc_exp_t;

  typedef struct {
    bit          dest;
    logic [DW-1:0] data;
  } push_exp_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic idle;
  logic error;

  vc_dest_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  vc_dest_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DB), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .idle(idle),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] vc0_fifo[$];
  logic [DW-1:0] vc1_fifo[$];
  logic [DW-1:0] d0_fifo[$];
  logic [DW-1:0] d1_fifo[$];
  cyc_exp_t      exp_cyc[$];
  push_exp_t     exp_push[$];
  int            grant_log[$];

  bit            s_pop0 = 0, s_pop1 = 0, s_push0 = 0, s_push1 = 0;
  logic [DW-1:0] s_data = '0;

  int fill_pct  = 0;
  int drain_pct = 100;
  bit force_af1 = 0;
  bit pulse_err = 0;

  int            m_mode = M_OFF;
  int            m_streak = 0;
  bit            m_pend = 0;
  logic [DW-1:0] m_pend_word = '0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: arbitration and routing rules applied to the queue contents.
  task automatic modelStep();
    cyc_exp_t  c;
    push_exp_t p;
    bit e0, e1, room, anyerr, g0, g1;
    e0     = (vc0_fifo.size() == 0);
    e1     = (vc1_fifo.size() == 0);
    room   = !(bus.d0_full || bus.d0_almost_full || bus.d1_full || bus.d1_almost_full);
    anyerr = bus.vc0_error || bus.vc1_error || bus.d0_error || bus.d1_error;
    g0 = 0;
    g1 = 0;
    c.skip_state = reset;
    c.idle       = (m_mode == M_OFF) && !m_pend;
    c.err        = (m_mode == M_HALT);
    c.dzero      = 1;
    if (!reset) begin
      if (m_pend && m_mode != M_HALT) begin
        p.dest = m_pend_word[DB];
        p.data = m_pend_word;
        exp_push.push_back(p);
        c.dzero = 0;
      end
      if (m_mode == M_RUN && room && !anyerr) begin
        if (!e0 && !(m_streak >= MH && !e1)) g0 = 1;
        else if (!e1) g1 = 1;
      end
    end
    c.pop0 = g0;
    c.pop1 = g1;
    exp_cyc.push_back(c);
    if (reset) begin
      m_mode   = M_OFF;
      m_streak = 0;
      m_pend   = 0;
    end else begin
      m_pend = g0 || g1;
      if (g0) m_pend_word = vc0_fifo[0];
      else if (g1) m_pend_word = vc1_fifo[0];
      if (e1 || g1) m_streak = 0;
      else if (g0 && m_streak < MH) m_streak++;
      if (anyerr) m_mode = M_HALT;
      else begin
        case (m_mode)
          M_OFF:   if (enable) m_mode = M_RUN;
          M_RUN:   if (!enable) m_mode = M_FIN;
          M_FIN:   m_mode = M_OFF;
          default: ;
        endcase
      end
    end
  endtask

  // One clock cycle: environment reacts to last cycle's strobes, then new inputs.
  task automatic applyStimulus(input bit rst, input bit en);
    @(posedge clk);
    #1;
    if (s_pop0 && vc0_fifo.size() > 0) bus.vc0_data = vc0_fifo.pop_front();
    if (s_pop1 && vc1_fifo.size() > 0) bus.vc1_data = vc1_fifo.pop_front();
    if (s_push0) begin
      checkOutput("d0_no_overflow", int'(d0_fifo.size() < DEPTH), 1);
      d0_fifo.push_back(s_data);
    end
    if (s_push1) begin
      checkOutput("d1_no_overflow", int'(d1_fifo.size() < DEPTH), 1);
      d1_fifo.push_back(s_data);
    end
    if (d0_fifo.size() > 0 && $urandom_range(99) < drain_pct) void'(d0_fifo.pop_front());
    if (d1_fifo.size() > 0 && $urandom_range(99) < drain_pct) void'(d1_fifo.pop_front());
    if ($urandom_range(99) < fill_pct && vc0_fifo.size() < 16) vc0_fifo.push_back(DW'($urandom));
    if ($urandom_range(99) < fill_pct && vc1_fifo.size() < 16) vc1_fifo.push_back(DW'($urandom));
    reset              = rst;
    enable             = en;
    bus.vc0_empty      = (vc0_fifo.size() == 0);
    bus.vc1_empty      = (vc1_fifo.size() == 0);
    bus.d0_full        = (d0_fifo.size() >= DEPTH);
    bus.d0_almost_full = (d0_fifo.size() >= DEPTH - 2);
    bus.d1_full        = (d1_fifo.size() >= DEPTH);
    bus.d1_almost_full = force_af1 || (d1_fifo.size() >= DEPTH - 2);
    bus.vc0_error      = 1'b0;
    bus.vc1_error      = pulse_err;
    bus.d0_error       = 1'b0;
    bus.d1_error       = 1'b0;
    modelStep();
  endtask

  initial begin : monitor
    cyc_exp_t  c;
    push_exp_t p;
    forever begin
      @(negedge clk);
      s_pop0  = bus.vc0_pop;
      s_pop1  = bus.vc1_pop;
      s_push0 = bus.d0_push;
      s_push1 = bus.d1_push;
      s_data  = bus.d_data;
      if (exp_cyc.size() > 0) begin
        c = exp_cyc.pop_front();
        checkOutput("vc0_pop", int'(s_pop0), int'(c.pop0));
        checkOutput("vc1_pop", int'(s_pop1), int'(c.pop1));
        if (!c.skip_state) begin
          checkOutput("idle", int'(idle), int'(c.idle));
          checkOutput("error", int'(error), int'(c.err));
        end
        if (c.dzero) checkOutput("d_data_zero", int'(s_data), 0);
        if (s_pop0) grant_log.push_back(0);
        else if (s_pop1) grant_log.push_back(1);
      end
      if (s_push0 || s_push1) begin
        checkOutput("single_push", int'(s_push0 && s_push1), 0);
        if (exp_push.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_push: d0_push=%0d d1_push=%0d data=%0h with none required",
                   s_push0, s_push1, s_data);
        end else begin
          p = exp_push.pop_front();
          checkOutput("push_dest", int'(s_push1), int'(p.dest));
          checkOutput("push_data", int'(s_data), int'(p.data));
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    enable = 1'b0;
    bus.vc0_empty = 1'b1;
    bus.vc1_empty = 1'b1;
    bus.vc0_error = 1'b0;
    bus.vc1_error = 1'b0;
    bus.vc0_data = '0;
    bus.vc1_data = '0;
    bus.d0_full = 1'b0;
    bus.d0_almost_full = 1'b0;
    bus.d1_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    bus.d0_error = 1'b0;
    bus.d1_error = 1'b0;

    $display("[TB] reset");
    repeat (2) applyStimulus(1, 0);
    applyStimulus(0, 0);

    $display("[TB] directed VC0 words 0x05, 0x12");
    vc0_fifo.push_back(6'h05);
    vc0_fifo.push_back(6'h12);
    repeat (6) applyStimulus(0, 1);

    $display("[TB] arbitration with both VCs busy");
    grant_log.delete();
    fill_pct = 100;
    repeat (12) applyStimulus(0, 1);
    checkOutput("grant_seq_len", int'(grant_log.size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) checkOutput($sformatf("grant_seq[%0d]", i), grant_log[i], (i % 4 == 3) ? 1 : 0);
    end

    $display("[TB] d1 almost-full backpressure");
    force_af1 = 1;
    applyStimulus(0, 1);
    @(negedge clk);
    grant_log.delete();
    repeat (6) applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("af_no_pops", grant_log.size(), 0);
    force_af1 = 0;
    repeat (4) applyStimulus(0, 1);

    $display("[TB] enable drop with word in flight");
    fill_pct = 0;
    applyStimulus(0, 0);
    repeat (4) applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("idle_after_drain", int'(idle), 1);

    $display("[TB] randomized traffic");
    fill_pct  = 60;
    drain_pct = 40;
    begin
      bit en_r = 1;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(99) < 8) en_r = !en_r;
        fill_pct = 30 + $urandom_range(60);
        applyStimulus(0, en_r);
      end
    end

    $display("[TB] vc1 error pulse");
    drain_pct = 100;
    fill_pct  = 100;
    repeat (5) applyStimulus(0, 1);
    pulse_err = 1;
    applyStimulus(0, 1);
    pulse_err = 0;
    repeat (6) applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(0, 0);

    $display("[TB] reset while a word is in flight");
    repeat (6) applyStimulus(0, 1);
    applyStimulus(1, 1);
    repeat (5) applyStimulus(0, 1);

    fill_pct = 0;
    repeat (8) applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("pushes_outstanding", exp_push.size(), 0);
    checkOutput("cycles_outstanding", exp_cyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
